// File: rtl/mouse_accum_if.sv
// Host mouse report bus into mouse_accum and the packed PS/2 packet back out.
// Latency: none, wires only.
// Backpressure: none; a report is a one-cycle strobe and the packet is a level with a toggle bit.
//   mouse_strobe : one-cycle pulse, new host report
//   mouse_x/y    : 9-bit two's-complement deltas, valid with mouse_strobe
//   mouse_flags  : host flags, bits [2:0] are the buttons
//   ps2_mouse    : {toggle, y[7:0], x[7:0], flags[7:0]}
interface mouse_accum_if;
    logic        mouse_strobe;
    logic [8:0]  mouse_x;
    logic [8:0]  mouse_y;
    logic [7:0]  mouse_flags;
    logic [24:0] ps2_mouse;

    // Report source (host side / testbench)
    modport master (
        output mouse_strobe,
        output mouse_x,
        output mouse_y,
        output mouse_flags,
        input  ps2_mouse
    );

    // Accumulator (mouse_accum)
    modport slave (
        input  mouse_strobe,
        input  mouse_x,
        input  mouse_y,
        input  mouse_flags,
        output ps2_mouse
    );
endinterface

// File: rtl/mouse_accum.sv
// Accumulates host mouse deltas and emits rate-limited PS/2 packets (toggle-flagged).
// Latency: max(1, GAP - gap_count) + 1 cycles from first qualifying strobe to the EMIT cycle.
// Backpressure: none; reports arriving while a packet is pending are summed into it.
//   clk_sys  : single system clock, rising edge
//   reset    : asynchronous active-high reset
//   mouse_if : slave side of mouse_accum_if (strobe/x/y/flags in, ps2_mouse out)
// Build option: define MOUSE_ACCUM_SAT_EN to clamp the accumulators to [-256,+255]
// with sticky overflow flags; otherwise the accumulators wrap modulo 512.
module mouse_accum #(
    parameter int GAP = 8400            // minimum clk_sys cycles between packets
) (
    input  logic          clk_sys,
    input  logic          reset,
    mouse_accum_if.slave  mouse_if
);

    localparam logic [15:0] GAP_INIT = 16'(GAP);      // reset value: immediately eligible
    localparam logic [15:0] GAP_THR  = 16'(GAP - 1);  // PEND leaves once count reaches this
    localparam logic [24:0] PS2_RST  = 25'h0000008;   // flags bit 3 is always set

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // nothing pending
        PEND = 2'd1,    // data pending, waiting for the gap to expire
        EMIT = 2'd2     // one cycle: packet register updates
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  acc_x_q, acc_x_d;
    logic [8:0]  acc_y_q, acc_y_d;
    logic        ovf_x_q, ovf_x_d;
    logic        ovf_y_q, ovf_y_d;
    logic [2:0]  btn_q,   btn_d;
    logic [15:0] gap_q,   gap_d;
    logic [24:0] ps2_q,   ps2_d;

    // Only the button bits of the host flags are meaningful.
    logic unused_flags;
    assign unused_flags = ^mouse_if.mouse_flags[7:3];

    // Returns {clipped, sum}. Operands are 9-bit two's complement.
    function automatic logic [9:0] add9(input logic [8:0] a, input logic [8:0] b);
`ifdef MOUSE_ACCUM_SAT_EN
        logic [9:0] s;
        s = {a[8], a} + {b[8], b};
        // Sign of the 10-bit sum differs from bit 8: result left the 9-bit range.
        if (s[9] != s[8]) begin
            return {1'b1, (s[9] ? 9'h100 : 9'h0FF)};
        end
        return {1'b0, s[8:0]};
`else
        return {1'b0, 9'(a + b)};
`endif
    endfunction

    // Combinational helpers for the accumulate path.
    logic [8:0]  base_x, base_y;
    logic        base_ovf_x, base_ovf_y;
    logic [9:0]  sum_x, sum_y;
    logic [2:0]  last_btn;
    logic        qualify;

    always_comb begin
        // In EMIT the current totals are being emitted, so a coincident report
        // starts a fresh accumulation instead of adding to what goes out.
        base_x     = acc_x_q;
        base_y     = acc_y_q;
        base_ovf_x = ovf_x_q;
        base_ovf_y = ovf_y_q;
        if (state_q == EMIT) begin
            base_x     = 9'h000;
            base_y     = 9'h000;
            base_ovf_x = 1'b0;
            base_ovf_y = 1'b0;
        end

        sum_x = add9(base_x, mouse_if.mouse_x);
        sum_y = add9(base_y, mouse_if.mouse_y);

        // Buttons last reported to the host side: during EMIT that is the set
        // being emitted right now, otherwise what sits in the packet register.
        last_btn = (state_q == EMIT) ? btn_q : ps2_q[2:0];

        qualify = (mouse_if.mouse_x != 9'h000) ||
                  (mouse_if.mouse_y != 9'h000) ||
                  (mouse_if.mouse_flags[2:0] != last_btn);
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        acc_x_d = base_x;
        acc_y_d = base_y;
        ovf_x_d = base_ovf_x;
        ovf_y_d = base_ovf_y;
        btn_d   = btn_q;
        ps2_d   = ps2_q;

        if (mouse_if.mouse_strobe) begin
            acc_x_d = sum_x[8:0];
            acc_y_d = sum_y[8:0];
            ovf_x_d = base_ovf_x | sum_x[9];
            ovf_y_d = base_ovf_y | sum_y[9];
            btn_d   = mouse_if.mouse_flags[2:0];
        end

        unique case (state_q)
            IDLE: begin
                if (mouse_if.mouse_strobe && qualify) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (gap_q >= GAP_THR) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                ps2_d = {~ps2_q[24], acc_y_q[7:0], acc_x_q[7:0],
                         ovf_y_q, ovf_x_q, acc_y_q[8], acc_x_q[8], 1'b1, btn_q};
                state_d = (mouse_if.mouse_strobe && qualify) ? PEND : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Gap counter restarts as EMIT begins and counts (saturating) otherwise,
        // so consecutive toggles are exactly GAP cycles apart when data waits.
        if (state_d == EMIT) begin
            gap_d = 16'h0000;
        end else if (gap_q == 16'hFFFF) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + 16'h0001;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_x_q <= 9'h000;
            acc_y_q <= 9'h000;
            ovf_x_q <= 1'b0;
            ovf_y_q <= 1'b0;
            btn_q   <= 3'b000;
            gap_q   <= GAP_INIT;
            ps2_q   <= PS2_RST;
        end else begin
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            ovf_x_q <= ovf_x_d;
            ovf_y_q <= ovf_y_d;
            btn_q   <= btn_d;
            gap_q   <= gap_d;
            ps2_q   <= ps2_d;
        end
    end

    assign mouse_if.ps2_mouse = ps2_q;

endmodule

// File: tb/tb_mouse_accum.sv
// Scoreboard bench for mouse_accum: reference model predicts each packet and its toggle cycle.
// Latency: packets are checked at the cycle the model predicts.
// Backpressure: none; stimulus and monitor run independently.
module tb_mouse_accum;
    localparam int GAP = 100;
    localparam int NEVER = -1000000;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    mouse_accum_if bus();

    mouse_accum #(.GAP(GAP)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .mouse_if (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [24:0] pkt;
        int          t;
    } exp_t;
    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // ---------------- reference model ----------------
    bit       m_pend;
    int       m_t, m_tp;
    int       m_ax, m_ay;
    bit       m_ox, m_oy;
    logic [2:0] m_btn, m_ebtn;
    bit       m_tog;

    function automatic int accum(input int acc, input int d, inout bit ovf);
        int v;
        v = acc + d;
`ifdef MOUSE_ACCUM_SAT_EN
        if (v > 255)  begin v = 255;  ovf = 1'b1; end
        if (v < -256) begin v = -256; ovf = 1'b1; end
`else
        if (v > 255)  v -= 512;
        if (v < -256) v += 512;
`endif
        return v;
    endfunction

    // Called before clock edge e with the inputs that edge will sample.
    task automatic model_step(input int e, input bit s, input int x, input int y,
                              input logic [7:0] f);
        exp_t ex;
        logic [8:0] vx, vy;
        bit qual;
        if (m_pend && m_t <= e) begin
            vx = 9'(m_ax);
            vy = 9'(m_ay);
            ex.pkt = {~m_tog, vy[7:0], vx[7:0], m_oy, m_ox, vy[8], vx[8], 1'b1, m_btn};
            ex.t   = m_t;
            q.push_back(ex);
            m_tog  = ~m_tog;
            m_tp   = m_t;
            m_ebtn = m_btn;
            m_pend = 1'b0;
            m_ax = 0; m_ay = 0; m_ox = 1'b0; m_oy = 1'b0;
        end
        if (s) begin
            qual  = (x != 0) || (y != 0) || (f[2:0] != m_ebtn);
            m_ax  = accum(m_ax, x, m_ox);
            m_ay  = accum(m_ay, y, m_oy);
            m_btn = f[2:0];
            if (!m_pend && qual) begin
                m_pend = 1'b1;
                m_t = (e + 2 > m_tp + GAP) ? e + 2 : m_tp + GAP;
            end
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_t = 0; m_tp = NEVER;
        m_ax = 0; m_ay = 0; m_ox = 1'b0; m_oy = 1'b0;
        m_btn = 3'b000; m_ebtn = 3'b000; m_tog = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic [24:0] last_ps2;
    int n_tog = 0;
    int tog_cyc = 0, prev_tog_cyc = 0;

    always begin
        @(posedge clk_sys);
        #1;
        if (reset) begin
            last_ps2 = bus.ps2_mouse;
        end else if (bus.ps2_mouse !== last_ps2) begin
            n_tog++;
            prev_tog_cyc = tog_cyc;
            tog_cyc      = cyc;
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pkt: got %h, want no change from %h (cycle %0d)",
                         bus.ps2_mouse, last_ps2, cyc);
            end else begin
                exp_t ex;
                ex = q.pop_front();
                check("pkt", bus.ps2_mouse, ex.pkt);
                check_int("pkt_cycle", cyc, ex.t);
            end
            last_ps2 = bus.ps2_mouse;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit s, input int x, input int y, input logic [7:0] f);
        @(negedge clk_sys);
        bus.mouse_strobe = s;
        bus.mouse_x      = 9'(x);
        bus.mouse_y      = 9'(y);
        bus.mouse_flags  = f;
        model_step(cyc + 1, s, x, y, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 8'h00);
    endtask

    task automatic wait_pkt();
        int n0;
        int k;
        n0 = n_tog;
        k  = 0;
        while (n_tog == n0 && k < 3 * GAP) begin
            tick(1'b0, 0, 0, 8'h00);
            k++;
        end
        if (n_tog == n0) begin
            n_chk++;
            $display("FAIL wait_pkt: no packet within %0d cycles (cycle %0d)", 3 * GAP, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_sys);
        reset = 1'b1;
        bus.mouse_strobe = 1'b0;
        #1;
        check("reset_value", bus.ps2_mouse, 25'h0000008);
        repeat (n) @(negedge clk_sys);
        check("reset_hold", bus.ps2_mouse, 25'h0000008);
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        int n0;
        logic [7:0] cur_f;
        logic [7:0] exp_x24, exp_f24;

        bus.mouse_strobe = 1'b0;
        bus.mouse_x      = 9'h000;
        bus.mouse_y      = 9'h000;
        bus.mouse_flags  = 8'h00;
        model_reset();
        do_reset(3);

        // First packet after reset: two cycles to EMIT, toggle the edge after.
        tick(1'b1, 5, -3, 8'h00);
        idle(3);
        check("first_pkt", bus.ps2_mouse, 25'h1FD0528);

        // Button-only change, then an identical report that must not emit.
        idle(GAP);
        tick(1'b1, 0, 0, 8'h01);
        idle(3);
        check("button_pkt", bus.ps2_mouse, 25'h0000009);
        idle(GAP);
        n0 = n_tog;
        tick(1'b1, 0, 0, 8'h01);
        idle(2 * GAP);
        check_int("repeat_no_pkt", n_tog, n0);

        // Three +10 strobes shortly after a packet merge into one, GAP later.
        tick(1'b1, 0, 1, 8'h01);
        wait_pkt();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 10, 0, 8'h01);
            idle(4);
        end
        wait_pkt();
        check("merge_x", {17'h0, bus.ps2_mouse[15:8]}, 25'h000001E);
        check_int("merge_spacing", tog_cyc - prev_tog_cyc, GAP);

        // Four +100 strobes: clamp or wrap depending on build.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 100, 0, 8'h01);
            idle(4);
        end
        wait_pkt();
`ifdef MOUSE_ACCUM_SAT_EN
        exp_x24 = 8'hFF; exp_f24 = 8'h49;
`else
        exp_x24 = 8'h90; exp_f24 = 8'h19;
`endif
        check("big_x", {17'h0, bus.ps2_mouse[15:8]}, {17'h0, exp_x24});
        check("big_flags", {17'h0, bus.ps2_mouse[7:0]}, {17'h0, exp_f24});

        // Strobe landing in the EMIT cycle starts the next packet on its own.
        tick(1'b1, 3, 0, 8'h01);
        while (cyc + 2 < m_t) tick(1'b0, 0, 0, 8'h00);
        tick(1'b1, 7, 0, 8'h01);
        wait_pkt();
        check("pre_emit_x", {17'h0, bus.ps2_mouse[15:8]}, 25'h0000003);
        wait_pkt();
        check("emit_coincident_x", {1'b0, bus.ps2_mouse[23:0]}, 25'h0000709);

        // Reset while a packet is pending discards it.
        tick(1'b1, 20, 0, 8'h01);
        idle(10);
        do_reset(2);
        n0 = n_tog;
        idle(2 * GAP);
        check_int("reset_discard", n_tog, n0);

        // Randomized traffic, checked by the scoreboard.
        cur_f = 8'h00;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                int x, y;
                if ($urandom_range(0, 3) == 0) begin
                    x = int'($urandom_range(0, 511)) - 256;
                    y = int'($urandom_range(0, 511)) - 256;
                end else begin
                    x = int'($urandom_range(0, 40)) - 20;
                    y = int'($urandom_range(0, 40)) - 20;
                end
                if ($urandom_range(0, 7) == 0) cur_f = 8'($urandom_range(0, 255));
                tick(1'b1, x, y, cur_f);
            end else begin
                tick(1'b0, 0, 0, cur_f);
            end
        end

        idle(3 * GAP);
        check_int("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mouse_accum.md
MOUSE_ACCUM -- requirements
Module: mouse_accum

Interface
REQ-001 The block SHALL have parameter GAP, default 8400, minimum clk_sys cycles between two emitted packets (100 us at 84 MHz).
REQ-002 The block SHALL have port clk_sys, input, 1, single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port mouse_strobe, input, 1, one-cycle pulse marking a new host mouse report.
REQ-005 The block SHALL have port mouse_x, input, 9, signed two's-complement X delta, valid with mouse_strobe.
REQ-006 The block SHALL have port mouse_y, input, 9, signed two's-complement Y delta, valid with mouse_strobe.
REQ-007 The block SHALL have port mouse_flags, input, 8, host flags; only bits [2:0] (buttons) are used.
REQ-008 The block SHALL have port ps2_mouse, output, 25, {toggle, y[7:0], x[7:0], flags[7:0]} packet for the tsconf PS2_MOUSE input.

Function
REQ-009 Each mouse_strobe SHALL add mouse_x/mouse_y, sign-extended, into 9-bit signed accumulators acc_x/acc_y and latch buttons = mouse_flags[2:0].
REQ-010 The FSM SHALL have states IDLE (nothing pending), PEND (data pending, gap counter running), EMIT (one cycle, packet update).
REQ-011 IDLE->PEND on mouse_strobe with nonzero delta or button change vs last emitted buttons; a strobe with zero delta and unchanged buttons SHALL NOT leave IDLE.
REQ-012 PEND->EMIT when gap counter >= GAP-1; the gap counter is 16-bit, clears on entering EMIT, and counts up saturating in every other state.
REQ-013 In EMIT: ps2_mouse[23:16]=acc_y[7:0], [15:8]=acc_x[7:0], flags={ovf_y, ovf_x, acc_y[8], acc_x[8], 1'b1, buttons}, toggle bit[24] inverts, then accumulators and overflow flags clear; EMIT->IDLE.
REQ-014 A strobe coincident with EMIT SHALL load the accumulators with the new delta (not add to emitted values); the FSM goes to PEND if it qualifies per REQ-011, else IDLE.
REQ-015 ps2_mouse SHALL change only in the EMIT cycle; output latency from the first qualifying strobe is max(1, GAP - gap_count) + 1 cycles.
REQ-016 Packets SHALL be at least GAP cycles apart (toggle-edge to toggle-edge).
REQ-017 Button changes SHALL be reported even with zero accumulated motion.

Reset
REQ-018 While reset is high: state=IDLE, acc_x=acc_y=0, ovf flags=0, buttons=0, gap counter=GAP (immediately eligible), ps2_mouse=25'h0000008.
REQ-019 Reset asserted mid-PEND SHALL discard pending data; no packet is emitted for it after release.

Configuration
REQ-020 Macro MOUSE_ACCUM_SAT_EN defined: accumulation SHALL clamp to [-256,+255] and set sticky ovf_x/ovf_y when clamping occurs.
REQ-021 Macro MOUSE_ACCUM_SAT_EN undefined: accumulation SHALL wrap modulo 512 and ovf_x/ovf_y SHALL stay 0.

Verification
REQ-022 After reset, strobe x=+5, y=-3, flags=0 -> one cycle later EMIT: ps2_mouse = {1, 8'hFD, 8'h05, 8'h28}.
REQ-023 GAP=100, three strobes of x=+10 within 50 cycles after a packet -> single packet with x=8'h1E, exactly 100 cycles after the previous toggle.
REQ-024 With SAT_EN, 4 strobes of x=+100 before emit -> x=8'hFF, flags[4]=0, flags[6]=1; without SAT_EN -> x=8'h90, flags[4]=1, flags[6]=0.
REQ-025 Strobe x=0, y=0, flags=8'h01 -> packet with flags=8'h09, x=y=0; a repeat identical strobe produces no packet.
REQ-026 Strobe x=+7 in the EMIT cycle of a prior packet -> the next packet carries x=8'h07 only.
REQ-027 Assert reset during PEND with x=+20 pending -> ps2_mouse=25'h0000008, no toggle for 2*GAP cycles after release.
